// File: rtl/gate_tester.sv
// Exhaustive tester for a two-input combinational gate. It drives every
// {a,b} vector in order, holds each one for SETTLE_CYCLES cycles, and
// compares the gate output against EXP_TT on the last settle edge. It counts
// mismatches and captures the first failing vector.
module gate_tester #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXP_TT        = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] fail_vec
);

  typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d, b_q, b_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [1:0] fvec_q, fvec_d;

  // Next-state logic: sequence the vectors, sample y_in on the last settle edge.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fvec_d  = fvec_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StDrive;
          vec_d   = 2'd0;
          cnt_d   = 4'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 3'd0;
          fv_d    = 1'b0;
          fvec_d  = 2'd0;
        end
      end
      StDrive: begin
        if (cnt_q == LastCnt) begin
          if (y_in != EXP_TT[vec_q]) begin
            err_d = err_q + 3'd1;
            // Only the first failing vector is recorded.
            if (!fv_q) begin
              fv_d   = 1'b1;
              fvec_d = vec_q;
            end
          end
          if (vec_q == 2'd3) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            vec_d = vec_q + 2'd1;
            cnt_d = 4'd0;
            a_d   = vec_d[1];
            b_d   = vec_d[0];
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    pass_d = done_d && (err_d == 3'd0);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fv_q    <= 1'b0;
      fvec_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fvec_q  <= fvec_d;
    end
  end

  assign a_out      = a_q;
  assign b_out      = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_gate_tester.sv
// Scoreboard bench for gate_tester: the stimulus pushes the expected result of
// each run, and a monitor checks the drive sequence, the latency and the
// final result every time done arrives.
module tb_gate_tester;

  localparam int S = 2;

  typedef struct {
    logic [2:0] err;
    logic       fv;
    logic [1:0] fvec;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       y_in;
  logic       a_out, b_out, busy, done, pass, fail_valid;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;

  int   gate_mode = 0;  // 0 NAND, 1 AND, 2 NAND faulted at {a,b}=10
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  gate_tester #(.SETTLE_CYCLES(S), .EXP_TT(4'b0111)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .y_in       (y_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .fail_valid (fail_valid),
    .fail_vec   (fail_vec)
  );

  always #5 clk = ~clk;

  // Gate under test.
  always_comb begin
    y_in = ~(a_out & b_out);
    if (gate_mode == 1) y_in = a_out & b_out;
    else if (gate_mode == 2) y_in = ~(a_out & b_out) ^ (a_out & ~b_out);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int err, input int fv, input int fvec, input int ps);
    exp_t e;
    e.err  = 3'(err);
    e.fv   = 1'(fv);
    e.fvec = 2'(fvec);
    e.pass = 1'(ps);
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_a"}, int'(a_out), 0);
    chk({tag, "_b"}, int'(b_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_fvalid"}, int'(fail_valid), 0);
    chk({tag, "_fvec"}, int'(fail_vec), 0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL done_timeout: done still 0 after 100 cycles");
  endtask

  task automatic wait_ab(input int ab);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (int'({a_out, b_out}) == ab) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL ab_timeout: vector %0d never driven", ab);
  endtask

  // Monitor: k counts negedges since the edge that accepted start.
  initial begin
    int   k;
    logic pb;
    exp_t e;
    k  = 0;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        k  = 0;
        pb = 1'b0;
      end else begin
        if (busy && !pb) k = 0;
        else if (busy || (done && pb)) k++;
        if (busy) chk("ab_seq", int'({a_out, b_out}), (k / S) & 3);
        if (done && pb) begin
          chk("latency", k, 4 * S);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL no_expect: done arrived with empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            chk("err_cnt", int'(err_cnt), int'(e.err));
            chk("fail_valid", int'(fail_valid), int'(e.fv));
            chk("fail_vec", int'(fail_vec), int'(e.fvec));
            chk("pass", int'(pass), int'(e.pass));
          end
        end
        pb = busy;
      end
    end
  end

  // Stimulus.
  initial begin
    #12;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);

    // Correct NAND; then confirm DONE holds its level and last vector.
    gate_mode = 0;
    push_exp(0, 0, 0, 1);
    pulse_start();
    wait_done();
    repeat (2) @(negedge clk);
    chk("done_hold", int'(done), 1);
    chk("ab_hold", int'({a_out, b_out}), 3);

    // AND checked against the NAND table: every vector fails.
    gate_mode = 1;
    push_exp(4, 1, 0, 0);
    pulse_start();
    wait_done();

    // Single fault at {a,b}=10.
    gate_mode = 2;
    push_exp(1, 1, 2, 0);
    pulse_start();
    wait_done();

    // Rerun from a failing DONE with a good gate.
    gate_mode = 0;
    push_exp(0, 0, 0, 1);
    pulse_start();
    wait_done();

    // start re-pulsed during vector 01 must be ignored.
    push_exp(0, 0, 0, 1);
    pulse_start();
    wait_ab(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset between edges during vector 10.
    push_exp(0, 0, 0, 1);
    pulse_start();
    wait_ab(2);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", int'(busy), 0);
    push_exp(0, 0, 0, 1);
    pulse_start();
    wait_done();

    // start held high: back-to-back runs, done high for one cycle only.
    push_exp(0, 0, 0, 1);
    push_exp(0, 0, 0, 1);
    @(negedge clk);
    start = 1'b1;
    wait_done();
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("rerun_busy", int'(busy), 1);
    start = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
